// File: rtl/sd_pkg.sv
// Shared definitions for the SD card responder: FSM states, command indices,
// CRC polynomials and a serial CRC7 step used for both the receive check and the response.
package sd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RXCMD,
    CHECK,
    NCR_GAP,
    TXRESP,
    NAC_GAP,
    TXDATA,
    TXDCRC,
    TXEND
  } sd_state_t;

  localparam logic [5:0]  CMD_GO_IDLE     = 6'd0;
  localparam logic [5:0]  CMD_READ_SINGLE = 6'd17;
  localparam logic [6:0]  CRC7_POLY       = 7'h09;
  localparam logic [15:0] CRC16_POLY      = 16'h1021;
  localparam int          FRAME_BITS      = 48;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_card_responder_if.sv
// Card bus bundle: SD CMD/DAT0 lines, bit strobe, backing RAM port and command report.
interface sd_card_responder_if;
  logic        sd_clk;
  logic        i_sd_cmd;
  logic        o_sd_cmd;
  logic        o_sd_data;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        crc_err;

  modport master (
    output sd_clk, i_sd_cmd, mem_rdata,
    input  o_sd_cmd, o_sd_data, mem_addr, cmd_valid, cmd_idx, cmd_arg, crc_err
  );

  modport slave (
    input  sd_clk, i_sd_cmd, mem_rdata,
    output o_sd_cmd, o_sd_data, mem_addr, cmd_valid, cmd_idx, cmd_arg, crc_err
  );
endinterface

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC-16-CCITT (x^16+x^12+x^5+1), init 0, one bit per enabled clk.
module sd_crc16_serial
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[15];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_card_responder.sv
// Card side of the 1-bit SD bus: receives commands, sends R1 responses, streams CMD17 blocks.
// Optional receive CRC7 check is enabled by defining SD_RESP_CRC_CHECK_EN.
module sd_card_responder
  import sd_pkg::*;
#(
  parameter int          NCR         = 2,
  parameter int          NAC         = 8,
  parameter int          BLOCK_BYTES = 512,
  parameter logic [31:0] CARD_STATUS = 32'h0000_0900
) (
  input  logic               clk,
  input  logic               rst,
  sd_card_responder_if.slave bus
);

  localparam int DW = $clog2(BLOCK_BYTES) + 3;
  localparam logic [DW-1:0] LAST_DATA_BIT = DW'(BLOCK_BYTES * 8 - 1);

  sd_state_t     state;
  logic [5:0]    bit_cnt;
  logic [15:0]   gap_cnt;
  logic [DW-1:0] data_cnt;
  logic          data_started;
  logic          is_read;
  logic [37:0]   rx_payload;
  logic [39:0]   tx_shift;
  logic [6:0]    crc7;
  logic [7:0]    byte_shift;
  logic          data_bit;
  logic          crc_ok;
  logic          crc16_clr;
  logic          crc16_en;
  logic [15:0]   crc16;

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       crc_err_q;
  assign crc_ok      = (crc7 == rx_crc);
  assign bus.crc_err = crc_err_q;
`else
  assign crc_ok      = 1'b1;
  assign bus.crc_err = 1'b0;
`endif

  // The first bit of every byte comes straight from RAM; the rest from the shift register.
  assign data_bit  = (data_cnt[2:0] == 3'd0) ? bus.mem_rdata[7] : byte_shift[7];
  assign crc16_clr = (state == NAC_GAP);
  assign crc16_en  = bus.sd_clk && (state == TXDATA) && data_started;

  sd_crc16_serial u_crc16 (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc16_clr),
    .en     (crc16_en),
    .bit_in (data_bit),
    .crc    (crc16)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.o_sd_cmd  <= 1'b1;
      bus.o_sd_data <= 1'b1;
      bus.mem_addr  <= 9'd0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_idx   <= 6'd0;
      bus.cmd_arg   <= 32'd0;
      bit_cnt       <= 6'd0;
      gap_cnt       <= 16'd0;
      data_cnt      <= '0;
      data_started  <= 1'b0;
      is_read       <= 1'b0;
      rx_payload    <= 38'd0;
      tx_shift      <= 40'd0;
      crc7          <= 7'd0;
      byte_shift    <= 8'd0;
`ifdef SD_RESP_CRC_CHECK_EN
      rx_crc        <= 7'd0;
      crc_err_q     <= 1'b0;
`endif
    end else begin
      bus.cmd_valid <= 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
      crc_err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.sd_clk && !bus.i_sd_cmd) begin
            state   <= RXCMD;
            bit_cnt <= 6'(FRAME_BITS - 2);
            crc7    <= 7'd0;
          end
        end

        // bit_cnt holds the frame index of the bit sampled on this strobe.
        RXCMD: begin
          if (bus.sd_clk) begin
            if (bit_cnt >= 6'd8) crc7 <= crc7_step(crc7, bus.i_sd_cmd);
            if (bit_cnt >= 6'd8 && bit_cnt <= 6'd45)
              rx_payload <= {rx_payload[36:0], bus.i_sd_cmd};
`ifdef SD_RESP_CRC_CHECK_EN
            if (bit_cnt >= 6'd1 && bit_cnt <= 6'd7)
              rx_crc <= {rx_crc[5:0], bus.i_sd_cmd};
`endif
            if (bit_cnt == 6'd46 && !bus.i_sd_cmd) state <= IDLE;
            else if (bit_cnt == 6'd0)              state <= CHECK;
            else                                   bit_cnt <= bit_cnt - 6'd1;
          end
        end

        CHECK: begin
          if (!crc_ok) begin
`ifdef SD_RESP_CRC_CHECK_EN
            crc_err_q <= 1'b1;
`endif
            state <= IDLE;
          end else begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_idx   <= rx_payload[37:32];
            bus.cmd_arg   <= rx_payload[31:0];
            is_read       <= (rx_payload[37:32] == CMD_READ_SINGLE);
            tx_shift      <= {2'b00, rx_payload[37:32], CARD_STATUS};
            crc7          <= 7'd0;
            gap_cnt       <= 16'(NCR);
            bit_cnt       <= 6'(FRAME_BITS - 1);
            state         <= (rx_payload[37:32] == CMD_GO_IDLE) ? IDLE : NCR_GAP;
          end
        end

        NCR_GAP: begin
          if (bus.sd_clk) begin
            bus.o_sd_cmd <= 1'b1;
            if (gap_cnt <= 16'd1) state <= TXRESP;
            else                  gap_cnt <= gap_cnt - 16'd1;
          end
        end

        // Header/status bits feed CRC7 as they go out, then the CRC register itself is shifted out.
        TXRESP: begin
          if (bus.sd_clk) begin
            if (bit_cnt >= 6'd8) begin
              bus.o_sd_cmd <= tx_shift[39];
              tx_shift     <= {tx_shift[38:0], 1'b0};
              crc7         <= crc7_step(crc7, tx_shift[39]);
            end else if (bit_cnt >= 6'd1) begin
              bus.o_sd_cmd <= crc7[6];
              crc7         <= {crc7[5:0], 1'b0};
            end else begin
              bus.o_sd_cmd <= 1'b1;
            end
            if (bit_cnt == 6'd0) begin
              if (is_read) begin
                state        <= NAC_GAP;
                gap_cnt      <= 16'(NAC);
                bus.mem_addr <= 9'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end

        NAC_GAP: begin
          if (bus.sd_clk) begin
            bus.o_sd_data <= 1'b1;
            if (gap_cnt <= 16'd1) begin
              state        <= TXDATA;
              data_started <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
        end

        // mem_addr steps while bit 1 goes out so the next byte has settled by its bit 7,
        // even when sd_clk is high on every clk.
        TXDATA: begin
          if (bus.sd_clk) begin
            if (!data_started) begin
              bus.o_sd_data <= 1'b0;
              data_started  <= 1'b1;
              data_cnt      <= '0;
            end else begin
              bus.o_sd_data <= data_bit;
              byte_shift    <= (data_cnt[2:0] == 3'd0) ? {bus.mem_rdata[6:0], 1'b0}
                                                       : {byte_shift[6:0], 1'b0};
              if (data_cnt[2:0] == 3'd6) bus.mem_addr <= bus.mem_addr + 9'd1;
              if (data_cnt == LAST_DATA_BIT) begin
                state   <= TXDCRC;
                bit_cnt <= 6'd15;
              end else begin
                data_cnt <= data_cnt + 1'b1;
              end
            end
          end
        end

        TXDCRC: begin
          if (bus.sd_clk) begin
            bus.o_sd_data <= crc16[bit_cnt[3:0]];
            if (bit_cnt == 6'd0) state <= TXEND;
            else                 bit_cnt <= bit_cnt - 6'd1;
          end
        end

        TXEND: begin
          if (bus.sd_clk) begin
            bus.o_sd_data <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_responder.sv
// Directed bench for sd_card_responder: acts as host and RAM, records CMD/DAT0 once per strobe.
module tb_sd_card_responder;
  import sd_pkg::*;

  localparam int          NCR    = 2;
  localparam int          NAC    = 8;
  localparam int          BYTES  = 512;
  localparam logic [31:0] STATUS = 32'h0000_0900;
  localparam int          DATA_START = NCR + 48 + NAC;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   crc_err_cnt = 0;
  bit   jitter = 1'b0;
  logic cmd_tr[$];
  logic dat_tr[$];
  logic ref_cmd[$];
  logic ref_dat[$];

  always #5 clk = ~clk;

  sd_card_responder_if bus ();

  sd_card_responder #(.NCR(NCR), .NAC(NAC), .BLOCK_BYTES(BYTES), .CARD_STATUS(STATUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: byte i holds i[7:0], one clk read latency.
  always @(posedge clk) bus.mem_rdata <= bus.mem_addr[7:0];

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) valid_cnt++;
    if (bus.crc_err === 1'b1)   crc_err_cnt++;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] crc7_model(input logic [39:0] v);
    logic [6:0] c;
    logic fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_model();
    logic [15:0] c;
    logic [7:0]  b;
    logic fb;
    c = 16'd0;
    for (int n = 0; n < BYTES; n++) begin
      b = n[7:0];
      for (int j = 7; j >= 0; j--) begin
        fb = b[j] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic trace_at(input logic q[$], input int k);
    if (k < 0 || k >= q.size()) return 1'bx;
    return q[k];
  endfunction

  function automatic int first_zero(input logic q[$]);
    for (int k = 0; k < q.size(); k++) if (q[k] === 1'b0) return k;
    return -1;
  endfunction

  function automatic int zeros_from(input logic q[$], input int from);
    int z;
    z = 0;
    for (int k = from; k < q.size(); k++) if (q[k] !== 1'b1) z++;
    return z;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic b);
    int gap;
    bus.i_sd_cmd = b;
    gap = jitter ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.sd_clk = 1'b1;
    @(posedge clk);
    #1;
    cmd_tr.push_back(bus.o_sd_cmd);
    dat_tr.push_back(bus.o_sd_data);
    bus.sd_clk = 1'b0;
  endtask

  // One idle clk after the end bit gives the card its CHECK cycle off-strobe.
  task automatic sendFrame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) strobe(f[i]);
    bus.i_sd_cmd = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sendCommand(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc_flip);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    sendFrame({head, crc7_model(head) ^ crc_flip, 1'b1});
  endtask

  task automatic applyStimulus(input int n);
    cmd_tr.delete();
    dat_tr.delete();
    for (int i = 0; i < n; i++) strobe(1'b1);
  endtask

  task automatic checkResponse(input string tag, input logic [5:0] idx, input bit with_data);
    logic [39:0] head;
    logic [47:0] exp_frame;
    logic [47:0] got;
    logic [7:0]  byte_v;
    logic [15:0] crc_v;
    int s, d, bad, base;
    head      = {2'b00, idx, STATUS};
    exp_frame = {head, crc7_model(head), 1'b1};
    s = first_zero(cmd_tr);
    checkOutput({tag, "_ncr_gap"}, 64'(s), 64'(NCR));
    got = '0;
    for (int i = 0; i < 48; i++) got = {got[46:0], trace_at(cmd_tr, s + i)};
    checkOutput({tag, "_r1_frame"}, 64'(got), 64'(exp_frame));
    checkOutput({tag, "_cmd_idle_after"}, 64'(zeros_from(cmd_tr, s + 48)), 64'd0);
    if (!with_data) begin
      checkOutput({tag, "_dat_quiet"}, 64'(zeros_from(dat_tr, 0)), 64'd0);
    end else begin
      d = first_zero(dat_tr);
      checkOutput({tag, "_dat_start"}, 64'(d), 64'(DATA_START));
      bad = 0;
      for (int n = 0; n < BYTES; n++) begin
        for (int j = 0; j < 8; j++) byte_v = {byte_v[6:0], trace_at(dat_tr, d + 1 + 8 * n + j)};
        if (byte_v !== n[7:0]) bad++;
        if (n == 0 || n == 255 || n == 256 || n == BYTES - 1)
          checkOutput($sformatf("%s_byte%0d", tag, n), 64'(byte_v), 64'(n[7:0]));
      end
      checkOutput({tag, "_bad_bytes"}, 64'(bad), 64'd0);
      base = d + 1 + 8 * BYTES;
      crc_v = '0;
      for (int j = 0; j < 16; j++) crc_v = {crc_v[14:0], trace_at(dat_tr, base + j)};
      checkOutput({tag, "_crc16"}, 64'(crc_v), 64'(crc16_model()));
      checkOutput({tag, "_end_bit"}, 64'(trace_at(dat_tr, base + 16)), 64'd1);
      checkOutput({tag, "_dat_idle_after"}, 64'(zeros_from(dat_tr, base + 17)), 64'd0);
    end
  endtask

  initial begin
    int v0, e0, mismatch;
    rst = 1'b1;
    bus.sd_clk = 1'b0;
    bus.i_sd_cmd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd", 64'(bus.o_sd_cmd), 64'd1);
    checkOutput("reset_dat", 64'(bus.o_sd_data), 64'd1);
    checkOutput("reset_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("reset_valid", 64'(bus.cmd_valid), 64'd0);
    checkOutput("reset_crc_err", 64'(bus.crc_err), 64'd0);
    checkOutput("reset_idx_arg", 64'({bus.cmd_idx, bus.cmd_arg}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] CMD0: accepted, no response");
    v0 = valid_cnt;
    sendCommand(CMD_GO_IDLE, 32'd0, 7'd0);
    applyStimulus(100);
    checkOutput("cmd0_valid", 64'(valid_cnt - v0), 64'd1);
    checkOutput("cmd0_idx", 64'(bus.cmd_idx), 64'd0);
    checkOutput("cmd0_cmd_quiet", 64'(zeros_from(cmd_tr, 0)), 64'd0);
    checkOutput("cmd0_dat_quiet", 64'(zeros_from(dat_tr, 0)), 64'd0);

    $display("[TB] CMD8: R1 response only");
    v0 = valid_cnt;
    sendCommand(6'd8, 32'h0000_01AA, 7'd0);
    applyStimulus(80);
    checkOutput("cmd8_valid", 64'(valid_cnt - v0), 64'd1);
    checkOutput("cmd8_idx", 64'(bus.cmd_idx), 64'd8);
    checkOutput("cmd8_arg", 64'(bus.cmd_arg), 64'h1AA);
    checkResponse("cmd8", 6'd8, 1'b0);

    $display("[TB] transmission bit 0: frame discarded");
    v0 = valid_cnt;
    sendFrame({2'b00, 46'h3FFF_FFFF_FFFF});
    applyStimulus(80);
    checkOutput("badframe_valid", 64'(valid_cnt - v0), 64'd0);
    checkOutput("badframe_cmd_quiet", 64'(zeros_from(cmd_tr, 0)), 64'd0);

    $display("[TB] CMD17: full block read");
    v0 = valid_cnt;
    sendCommand(CMD_READ_SINGLE, 32'h10, 7'd0);
    applyStimulus(4250);
    checkOutput("cmd17_valid", 64'(valid_cnt - v0), 64'd1);
    checkOutput("cmd17_arg", 64'(bus.cmd_arg), 64'h10);
    checkResponse("cmd17", CMD_READ_SINGLE, 1'b1);
    ref_cmd = cmd_tr;
    ref_dat = dat_tr;

    $display("[TB] CMD17 with irregular sd_clk");
    jitter = 1'b1;
    sendCommand(CMD_READ_SINGLE, 32'h10, 7'd0);
    applyStimulus(4250);
    jitter = 1'b0;
    mismatch = 0;
    for (int k = 0; k < ref_cmd.size(); k++)
      if (trace_at(cmd_tr, k) !== ref_cmd[k] || trace_at(dat_tr, k) !== ref_dat[k]) mismatch++;
    checkOutput("jitter_trace_len", 64'(dat_tr.size()), 64'(ref_dat.size()));
    checkOutput("jitter_trace_diff", 64'(mismatch), 64'd0);

    $display("[TB] reset during data byte 100");
    sendCommand(CMD_READ_SINGLE, 32'h10, 7'd0);
    applyStimulus(DATA_START + 1 + 800 + 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_dat", 64'(bus.o_sd_data), 64'd1);
    checkOutput("midreset_addr", 64'(bus.mem_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sendCommand(CMD_READ_SINGLE, 32'h10, 7'd0);
    applyStimulus(4250);
    checkResponse("after_reset", CMD_READ_SINGLE, 1'b1);

`ifdef SD_RESP_CRC_CHECK_EN
    $display("[TB] CMD17 with corrupted CRC7, check enabled");
    v0 = valid_cnt;
    e0 = crc_err_cnt;
    sendCommand(CMD_READ_SINGLE, 32'h10, 7'h01);
    applyStimulus(200);
    checkOutput("badcrc_err", 64'(crc_err_cnt - e0), 64'd1);
    checkOutput("badcrc_valid", 64'(valid_cnt - v0), 64'd0);
    checkOutput("badcrc_cmd_quiet", 64'(zeros_from(cmd_tr, 0)), 64'd0);
    checkOutput("badcrc_dat_quiet", 64'(zeros_from(dat_tr, 0)), 64'd0);
`else
    $display("[TB] CMD8 with corrupted CRC7, check disabled");
    v0 = valid_cnt;
    e0 = crc_err_cnt;
    sendCommand(6'd8, 32'h0000_01AA, 7'h01);
    applyStimulus(80);
    checkOutput("badcrc_err", 64'(crc_err_cnt - e0), 64'd0);
    checkOutput("badcrc_valid", 64'(valid_cnt - v0), 64'd1);
    checkResponse("badcrc_cmd8", 6'd8, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
